// File: rtl/mux_rr_scheduler.sv
// Four-channel 1-deep-buffered arbiter feeding the 4:1 mux; round robin, or fixed a>b>c>d priority with MUX_SCHED_FIXED_PRIO_EN.
// Accepted word is presented one edge later; out_data/out_ch/sel* hold while out_valid & ~out_ready.
module mux_rr_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [3:0]       full;
    logic [WIDTH-1:0] buf_q [4];
    logic [WIDTH-1:0] din   [4];
    logic [1:0]       last_grant;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             grant_vld;
    logic             load;

    always_comb begin
        din[0] = a;
        din[1] = b;
        din[2] = c;
        din[3] = d;
    end

    assign in_ready = ~full;

    // Only flags set before this edge compete, so a word landing now waits a cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 2'd0;
        idx       = 2'd0;
`ifdef MUX_SCHED_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            idx = 2'(i);
            if (full[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
`else
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant + 2'(k);
            if (full[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
`endif
    end

    assign load = grant_vld & ((state == IDLE) | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = BUSY;
            BUSY:    if (out_ready && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == BUSY);
    end

    // Accept and drain of one channel are exclusive: accept needs ~full, drain needs full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    full[i]  <= 1'b1;
                    buf_q[i] <= din[i];
                end else if (load && (grant == 2'(i))) begin
                    full[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_ch     <= 2'd0;
            last_grant <= 2'd3;
        end else if (load) begin
            out_data   <= buf_q[grant];
            out_ch     <= grant;
            last_grant <= grant;
        end
    end

    assign sel1 = out_ch[0];
    assign sel2 = out_ch[0];
    assign sel3 = out_ch[1];

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin source scheduler that sits directly upstream of the team's 8-bit four-input mux (a, b, c, d with sel1, sel2, sel3). Four producer channels each hand words in over valid/ready. The block buffers one word per channel, picks the next channel in round-robin order, and presents the chosen word on a registered valid/ready output. It also drives the matching select lines for the downstream mux. It replaces ad-hoc stepping of the select lines with a flow-controlled arbiter.

## Interface
- WIDTH, 8, data width of every channel and of out_data.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-channel valid; bit 0 = channel a … bit 3 = channel d.
- in_ready  output  4  per-channel ready; equals the inverse of that channel's buffer-full flag.
- a, b, c, d  input  WIDTH each  channel data, sampled when the matching in_valid and in_ready bits are both high.
- out_valid  output  1  out_data/out_ch hold a granted word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  granted word (registered).
- out_ch  output  2  index of the granted channel (0=a, 1=b, 2=c, 3=d).
- sel1, sel2, sel3  output  1 each  downstream mux selects, registered with out_ch: sel1 = out_ch[0] (a/b), sel2 = out_ch[0] (c/d), sel3 = out_ch[1] (pair).

## Operation
- Per-channel 1-entry buffer with a full flag.
  - Accept on in_valid[i] & in_ready[i]; data is latched and full[i] set at that edge.
  - in_ready[i] = ~full[i]. A buffer is never refilled in the cycle it is drained, so the maximum rate is one word per channel every 2 cycles.
- Two-state FSM: IDLE (out_valid=0) and BUSY (out_valid=1).
- Load condition: (IDLE) or (BUSY & out_ready), together with at least one full buffer.
  - On load, the winner's buffer moves into out_data/out_ch/sel*.
  - The winner's full flag clears.
  - The winner becomes last_grant.
- IDLE→BUSY on load.
- BUSY & out_ready & a load → stays BUSY, with a back-to-back new word.
- BUSY & out_ready & no full buffer → IDLE; out_data/out_ch/sel* keep their last values.
- BUSY & ~out_ready → hold everything stable. out_data, out_ch and sel* must not change while out_valid=1 and out_ready=0.
- Round robin: search channels last_grant+1, +2, +3, +4 (mod 4); the first full one wins. The 2-bit index wraps 3→0.
- A word arriving at an edge is not eligible for arbitration until the next cycle. Only flags already set are considered.

## Timing
- Reset values while rst_n=0, applied immediately:
  - full=0000, in_ready=1111.
  - out_valid=0, out_data=0, out_ch=0, sel1=sel2=sel3=0.
  - last_grant=3, FSM=IDLE.
- Latency: word accepted at edge k → out_valid=1 with that word after edge k+1, provided the output register is free.
- Sustained throughput: one word per cycle at the output when at least two channels are active.
- Reset asserted mid-transfer discards all buffered and presented words. No partial handshake survives reset.

## Configuration
- MUX_SCHED_FIXED_PRIO_EN
  - Defined: arbitration is fixed priority a > b > c > d; last_grant is still maintained but ignored.
  - Not defined (default): round robin as described above.

## Test plan
- Reset check: hold rst_n=0 with all in_valid=1111 → in_ready=1111, out_valid=0, out_data=8'h00, sel*=0. Release rst_n with out_ready=1 → first grant is channel a.
- Single channel: in_valid=0100, c=8'hAA at edge k, out_ready=1 → after edge k+1: out_valid=1, out_data=8'hAA, out_ch=2, {sel3,sel2,sel1}=3'b100, in_ready[2]=1.
- Round robin: load a=8'h00, b=8'hF0, c=8'hAA, d=8'h55 in one cycle, out_ready=1 → out_data sequence 00, F0, AA, 55 on consecutive cycles. Reload all four → order restarts at a. With FIXED_PRIO defined and a refilled every 2 cycles, b/c/d wait while a is full.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data/out_ch/sel* stable, and other channels' in_ready drop once filled. Then out_ready=1 → words drain in round-robin order with no loss or duplication.
- Wrap-around: last_grant=3 (channel d just granted), channels a and d full → next grant is a.
- Mid-operation reset: assert rst_n=0 while out_valid=1 and two buffers are full → all outputs return to reset values at once, and no stale word appears after release.
